// File: rtl/platform_pkg.sv
// Shared constants and types for the platform field: group geometry, coordinates,
// activation masks and the scroll FSM state encoding.
package platform_pkg;

    localparam int NUM_GROUPS     = 6;
    localparam int GROUP_SIZE     = 15;
    localparam int ROWS_PER_GROUP = 5;
    localparam int COLS           = 3;
    localparam int PLATFORM_H     = 30;
    localparam int RECYCLE_DY     = 948;

    typedef logic signed [10:0] coord_t;
    typedef logic [2:0]         group_idx_t;
    typedef logic [14:0]        mask_t;

    typedef enum logic {
        IDLE   = 1'b0,
        SCROLL = 1'b1
    } scroll_state_t;

    // Lowest set index wins, so the group closest to the start of the field is served first.
    function automatic group_idx_t lowest_set(input logic [NUM_GROUPS-1:0] v);
        group_idx_t idx;
        idx = '0;
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (v[i]) idx = group_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/platform_mask_shaper.sv
// Turns raw LFSR bits into a playable activation mask: optionally at least one
// platform per 3-wide row, and never an entirely empty group.
module platform_mask_shaper
    import platform_pkg::*;
#(
    parameter int MIN_ONE_PER_ROW = 1
) (
    input  mask_t raw_i,
    output mask_t mask_o
);

    always_comb begin
        mask_o = raw_i;
        if (MIN_ONE_PER_ROW != 0) begin
            for (int r = 0; r < ROWS_PER_GROUP; r++) begin
                // The middle column is the safest landing spot for an otherwise empty row.
                if (raw_i[COLS*r +: COLS] == 3'b000) mask_o[COLS*r + 1] = 1'b1;
            end
        end
        if (mask_o == '0) mask_o[GROUP_SIZE-1] = 1'b1;
    end

endmodule

// File: rtl/platform_scroll_scheduler.sv
// Frame-level sequencer for the platform field: scrolls after qualifying landings,
// keeps the height score, and issues per-group recycle requests to storage.
module platform_scroll_scheduler
    import platform_pkg::*;
#(
    parameter int SCROLL_FRAMES   = 16,
    parameter int STEP            = 12,
    parameter int SCROLL_LINE     = 400,
    parameter int EARTH           = 480,
    parameter int MIN_ONE_PER_ROW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  landing,
    input  logic [9:0]            doodle_y,
    input  coord_t                group_top_y [NUM_GROUPS],
    input  logic [14:0]           rand_bits,
    output logic                  scroll_en,
    output logic [4:0]            scroll_dy,
    output logic                  recycle_valid,
    output group_idx_t            recycle_group,
    output mask_t                 recycle_mask,
    input  logic                  recycle_ready,
    output logic                  busy,
    output logic [19:0]           height_score,
    output scroll_state_t         dbg_state,
    output logic [NUM_GROUPS-1:0] dbg_pending
);

    localparam int               FL_W        = $clog2(SCROLL_FRAMES + 1);
    localparam logic [FL_W-1:0]  FRAMES_INIT = FL_W'(SCROLL_FRAMES);
    localparam logic [FL_W-1:0]  FRAMES_ONE  = FL_W'(1);
    localparam logic [9:0]       LINE_Y      = 10'(SCROLL_LINE);
    localparam coord_t           EARTH_Y     = coord_t'(EARTH);
    localparam logic [19:0]      STEP_H      = 20'(STEP);
    localparam logic [19:0]      HEIGHT_MAX  = '1;

    scroll_state_t         state_q, state_d;
    logic [FL_W-1:0]       frames_left_q, frames_left_d;
    logic [19:0]           height_q, height_d;
    logic [NUM_GROUPS-1:0] pending_q, pending_d;
    logic [NUM_GROUPS-1:0] snap;
    logic                  valid_q, valid_d;
    group_idx_t            group_q, group_d;
    mask_t                 mask_q, mask_d;
    mask_t                 shaped_mask;
    logic                  land_ok;
    logic                  xfer;

    platform_mask_shaper #(
        .MIN_ONE_PER_ROW(MIN_ONE_PER_ROW)
    ) u_shaper (
        .raw_i (rand_bits),
        .mask_o(shaped_mask)
    );

    assign land_ok = landing && (doodle_y < LINE_Y);

    // Step first, then a same-cycle landing reloads the counter (restart, never accumulate).
    always_comb begin
        state_d       = state_q;
        frames_left_d = frames_left_q;
        height_d      = height_q;
        scroll_en     = 1'b0;
        if (state_q == SCROLL && frame_tick) begin
            scroll_en     = 1'b1;
            frames_left_d = frames_left_q - FRAMES_ONE;
            height_d      = (height_q > HEIGHT_MAX - STEP_H) ? HEIGHT_MAX : height_q + STEP_H;
            if (frames_left_q == FRAMES_ONE) state_d = IDLE;
        end
        if (land_ok) begin
            state_d       = SCROLL;
            frames_left_d = FRAMES_INIT;
        end
    end

    // Handshake: recycle_valid/group/mask are registered and held stable while
    // valid && !ready; a transfer happens on the edge where valid && ready, and
    // valid drops for at least one cycle before the next request.
    assign xfer = valid_q && recycle_ready;

    always_comb begin
        snap = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            snap[g] = (group_top_y[g] >= EARTH_Y);
        end
    end

    always_comb begin
        pending_d = pending_q;
        valid_d   = valid_q;
        group_d   = group_q;
        mask_d    = mask_q;
        if (frame_tick) pending_d = pending_d | snap;
        // Storage only moves the group on this edge, so its fresh snapshot bit is stale.
        if (xfer) begin
            pending_d[group_q] = 1'b0;
            valid_d            = 1'b0;
        end else if (!valid_q && pending_q != '0) begin
            valid_d = 1'b1;
            group_d = lowest_set(pending_q);
            mask_d  = shaped_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            frames_left_q <= '0;
            height_q      <= '0;
            pending_q     <= '0;
            valid_q       <= 1'b0;
            group_q       <= '0;
            mask_q        <= '0;
        end else begin
            state_q       <= state_d;
            frames_left_q <= frames_left_d;
            height_q      <= height_d;
            pending_q     <= pending_d;
            valid_q       <= valid_d;
            group_q       <= group_d;
            mask_q        <= mask_d;
        end
    end

    assign scroll_dy     = 5'(STEP);
    assign recycle_valid = valid_q;
    assign recycle_group = group_q;
    assign recycle_mask  = mask_q;
    assign height_score  = height_q;
    assign busy          = (state_q == SCROLL) || (pending_q != '0) || valid_q;
    assign dbg_state     = state_q;
    assign dbg_pending   = pending_q;

endmodule

// File: tb/tb_platform_scroll_scheduler.sv
// Directed bench: scroll counting, landing qualification, recycle ordering and
// handshake corners, plus a table of mask-shaping vectors for both row policies.
module tb_platform_scroll_scheduler;
    import platform_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_tick;
    logic          landing;
    logic [9:0]    doodle_y;
    coord_t        gy [NUM_GROUPS];
    logic [14:0]   rand_bits;
    logic          recycle_ready;

    logic          scroll_en, scroll_en0;
    logic [4:0]    scroll_dy, scroll_dy0;
    logic          recycle_valid, recycle_valid0;
    group_idx_t    recycle_group, recycle_group0;
    mask_t         recycle_mask, recycle_mask0;
    logic          busy, busy0;
    logic [19:0]   height_score, height_score0;
    scroll_state_t dbg_state, dbg_state0;
    logic [5:0]    dbg_pending, dbg_pending0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        logic [14:0] rnd;
        logic [14:0] m1;
        logic [14:0] m0;
    } mask_vec_t;
    mask_vec_t vecs [5];

    always #5 clk = ~clk;

    platform_scroll_scheduler #(.MIN_ONE_PER_ROW(1)) u_dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .landing(landing),
        .doodle_y(doodle_y), .group_top_y(gy), .rand_bits(rand_bits),
        .scroll_en(scroll_en), .scroll_dy(scroll_dy), .recycle_valid(recycle_valid),
        .recycle_group(recycle_group), .recycle_mask(recycle_mask),
        .recycle_ready(recycle_ready), .busy(busy), .height_score(height_score),
        .dbg_state(dbg_state), .dbg_pending(dbg_pending)
    );

    platform_scroll_scheduler #(.MIN_ONE_PER_ROW(0)) u_dut0 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .landing(landing),
        .doodle_y(doodle_y), .group_top_y(gy), .rand_bits(rand_bits),
        .scroll_en(scroll_en0), .scroll_dy(scroll_dy0), .recycle_valid(recycle_valid0),
        .recycle_group(recycle_group0), .recycle_mask(recycle_mask0),
        .recycle_ready(recycle_ready), .busy(busy0), .height_score(height_score0),
        .dbg_state(dbg_state0), .dbg_pending(dbg_pending0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; frame_tick = 1'b0; landing = 1'b0; doodle_y = '0;
        rand_bits = '0; recycle_ready = 1'b0;
        for (int g = 0; g < NUM_GROUPS; g++) gy[g] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
    endtask

    task automatic do_landing(input logic [9:0] dy);
        @(negedge clk); landing = 1'b1; doodle_y = dy;
        @(negedge clk); landing = 1'b0;
    endtask

    // One frame: tick high for one cycle, scroll_en sampled mid-cycle, then one quiet cycle.
    task automatic do_frame(input logic land, input logic [9:0] dy);
        @(negedge clk); frame_tick = 1'b1; landing = land; doodle_y = dy;
        #1; if (scroll_en) pulses++;
        @(negedge clk); frame_tick = 1'b0; landing = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!recycle_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(name, recycle_valid, 1);
    endtask

    task automatic handshake();
        recycle_ready = 1'b1;
        @(negedge clk);
        recycle_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{15'b000_000_111_000_000, 15'b010_010_111_010_010, 15'b000_000_111_000_000};
        vecs[1] = '{15'b000_000_000_000_000, 15'b010_010_010_010_010, 15'h4000};
        vecs[2] = '{15'b111_111_111_111_111, 15'b111_111_111_111_111, 15'b111_111_111_111_111};
        vecs[3] = '{15'b100_001_000_010_000, 15'b100_001_010_010_010, 15'b100_001_000_010_000};
        vecs[4] = '{15'b000_101_000_000_001, 15'b010_101_010_010_001, 15'b000_101_000_000_001};

        // Reset state
        do_reset();
        #1;
        check("rst_scroll_en", scroll_en, 0);
        check("rst_scroll_dy", scroll_dy, 12);
        check("rst_valid", recycle_valid, 0);
        check("rst_group", recycle_group, 0);
        check("rst_mask", recycle_mask, 0);
        check("rst_busy", busy, 0);
        check("rst_height", height_score, 0);
        check("rst_state", dbg_state, IDLE);
        check("rst_pending", dbg_pending, 0);

        // Basic landing: 16 pulses out of 20 frames
        do_landing(10'd200);
        check("land_state", dbg_state, SCROLL);
        check("land_busy", busy, 1);
        for (int i = 0; i < 20; i++) do_frame(1'b0, '0);
        check("basic_pulses", pulses, 16);
        check("basic_height", height_score, 192);
        check("basic_busy", busy, 0);
        check("basic_state", dbg_state, IDLE);

        // Landing below the scroll line is ignored
        pulses = 0;
        do_landing(10'd450);
        check("low_land_state", dbg_state, IDLE);
        for (int i = 0; i < 3; i++) do_frame(1'b0, '0);
        check("low_land_pulses", pulses, 0);
        check("low_land_height", height_score, 192);

        // Landing exactly at the line is also ignored
        do_landing(10'd400);
        check("line_land_state", dbg_state, IDLE);

        // Second landing after the 5th step restarts the count
        do_reset();
        do_landing(10'd200);
        for (int i = 0; i < 5; i++) do_frame(1'b0, '0);
        check("relanding_first5", pulses, 5);
        do_landing(10'd200);
        for (int i = 0; i < 25; i++) do_frame(1'b0, '0);
        check("relanding_pulses", pulses, 21);
        check("relanding_height", height_score, 252);
        check("relanding_busy", busy, 0);

        // Landing and tick together: step issued, then counter reloads
        do_reset();
        do_landing(10'd200);
        for (int i = 0; i < 3; i++) do_frame(1'b0, '0);
        do_frame(1'b1, 10'd100);
        check("same_cycle_pulse_taken", pulses, 4);
        for (int i = 0; i < 20; i++) do_frame(1'b0, '0);
        check("same_cycle_pulses", pulses, 20);
        check("same_cycle_height", height_score, 240);

        // Two groups past the earth line: lowest index first, stable while stalled
        do_reset();
        gy[2] = 11'sd486;
        gy[4] = 11'sd500;
        gy[5] = -11'sd5;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd4);
        rand_bits = vecs[0].rnd;
        do_frame(1'b0, '0);
        for (int g = 0; g < NUM_GROUPS; g++) gy[g] = '0;
        check("two_grp_pending", dbg_pending, 6'b010100);
        wait_valid("two_grp_valid_a");
        check("two_grp_group_a", recycle_group, exp_q.pop_front());
        check("two_grp_mask_a", recycle_mask, vecs[0].m1);
        rand_bits = 15'h7fff;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rand_bits = 15'(i * 3 + 1);
            check("stall_valid", recycle_valid, 1);
            check("stall_group", recycle_group, 2);
            check("stall_mask", recycle_mask, vecs[0].m1);
        end
        rand_bits = vecs[1].rnd;
        handshake();
        check("gap_after_xfer", recycle_valid, 0);
        wait_valid("two_grp_valid_b");
        check("two_grp_group_b", recycle_group, exp_q.pop_front());
        check("two_grp_mask_b", recycle_mask, vecs[1].m1);
        handshake();
        repeat (2) @(negedge clk);
        check("two_grp_pending_done", dbg_pending, 0);
        check("two_grp_valid_done", recycle_valid, 0);
        check("two_grp_busy_done", busy, 0);

        // Threshold boundary and signed compare: 479 and -5 are not recycled
        gy[0] = 11'sd479;
        gy[1] = -11'sd5;
        do_frame(1'b0, '0);
        gy[0] = '0; gy[1] = '0;
        repeat (3) @(negedge clk);
        check("below_earth_pending", dbg_pending, 0);
        check("below_earth_valid", recycle_valid, 0);

        // Mask shaping table, both row policies, group 0 at exactly EARTH
        for (int v = 0; v < 5; v++) begin
            gy[0] = 11'sd480;
            rand_bits = vecs[v].rnd;
            do_frame(1'b0, '0);
            gy[0] = '0;
            wait_valid("vec_valid");
            check("vec_group", recycle_group, 0);
            check("vec_mask_row", recycle_mask, vecs[v].m1);
            check("vec_valid_norow", recycle_valid0, 1);
            check("vec_mask_norow", recycle_mask0, vecs[v].m0);
            handshake();
        end

        // Handshake on group 1 in the same cycle as a tick that still sees it past earth
        do_reset();
        gy[1] = 11'sd482;
        do_frame(1'b0, '0);
        wait_valid("hs_tick_valid");
        check("hs_tick_group", recycle_group, 1);
        recycle_ready = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        recycle_ready = 1'b0;
        frame_tick = 1'b0;
        gy[1] = '0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (recycle_valid) seen = 1'b1;
            end
            check("hs_tick_no_reissue", seen, 0);
        end
        check("hs_tick_pending", dbg_pending, 0);

        // Reset with a request outstanding
        gy[3] = 11'sd490;
        do_frame(1'b0, '0);
        gy[3] = '0;
        wait_valid("rst_mid_valid");
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid_drop", recycle_valid, 0);
        check("rst_mid_pending", dbg_pending, 0);
        rst = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (recycle_valid) seen = 1'b1;
            end
            check("rst_mid_no_request", seen, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/platform_scroll_scheduler.md
Name: platform_scroll_scheduler

Overview:
- Frame-level controller that sequences the platform field.
- Decides when and how long the field scrolls after a landing, and emits one scroll step per frame.
- Detects platform groups that have passed the earth line and issues per-group recycle requests, each with a shaped random activation mask, over a valid/ready handshake.
- Sits between doodle collision logic, the LFSR and the platform storage/draw block; also keeps the height score.

Parameters:
- SCROLL_FRAMES, 16, frames scrolled per landing.
- STEP, 12, pixels added to every platform y per scroll frame.
- SCROLL_LINE, 400, landing scrolls only if doodle_y < SCROLL_LINE.
- EARTH, 480, signed y at or beyond which a group is recycled.
- MIN_ONE_PER_ROW, 1, force at least one active platform per 3-wide row of a mask.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous, active-high reset.
- frame_tick, input, 1, one-cycle pulse per frame.
- landing, input, 1, one-cycle pulse: doodle hit a platform moving down.
- doodle_y, input, 10, doodle top y at the landing pulse.
- group_top_y, input, 6x11 signed, y of the first platform of each group.
- rand_bits, input, 15, LFSR output.
- scroll_en, output, 1, one-cycle pulse: storage adds scroll_dy this cycle.
- scroll_dy, output, 5, constant STEP.
- recycle_valid, output, 1, recycle request pending.
- recycle_group, output, 3, group index 0..5.
- recycle_mask, output, 15, activation bits for that group.
- recycle_ready, input, 1, storage accepts; it subtracts the recycle offset and loads the mask on the same edge.
- busy, output, 1, scrolling or recycles pending.
- height_score, output, 20, accumulated scrolled pixels, saturating.

Behaviour:
- Reset: all outputs 0 except scroll_dy = STEP; pending = 0; frames_left = 0; FSM in IDLE.
- Reset mid-handshake drops recycle_valid on the next cycle with no transfer.
- Scroll FSM: IDLE and SCROLL.
  - landing with doodle_y < SCROLL_LINE (any state): frames_left <= SCROLL_FRAMES, go to SCROLL. A landing in SCROLL restarts the count; it does not add to it.
  - landing with doodle_y >= SCROLL_LINE: ignored.
  - In SCROLL on frame_tick: scroll_en = 1 in that same cycle (combinational from state & frame_tick), frames_left decrements, height_score += STEP saturating at 2^20-1.
  - frames_left reaching 0 returns the FSM to IDLE; exactly SCROLL_FRAMES pulses per uninterrupted landing.
  - landing and frame_tick in the same cycle: the step is issued, then the counter reloads to SCROLL_FRAMES.
- Recycle scan:
  - On frame_tick, pending[g] |= (group_top_y[g] >= EARTH), signed compare, on pre-scroll values.
  - If a handshake completes on group g in the same cycle, pending[g] is cleared and the new snapshot bit for g is ignored, because storage has not yet updated.
- Issuer:
  - While pending != 0 and not holding a request, pick the lowest set index, assert recycle_valid next cycle, and latch recycle_group and recycle_mask from rand_bits.
  - Group and mask stay stable while valid && !ready.
  - Transfer on valid && ready; pending bit cleared; the next request may assert on the following cycle. Maximum throughput is one request per 2 cycles.
- Mask shaping:
  - If MIN_ONE_PER_ROW and a row's bits [3r+2:3r] are all 0 (r = 0..4), set bit 3r+1.
  - Otherwise, if the whole mask is 0, set bit 14.
- busy = (state == SCROLL) | (pending != 0) | recycle_valid.

Decomposition:
- Package platform_pkg:
  - Constants: NUM_GROUPS = 6, GROUP_SIZE = 15, ROWS_PER_GROUP = 5, COLS = 3, PLATFORM_H = 30, RECYCLE_DY = 948.
  - Typedefs: coord_t (signed [10:0]), group_idx_t ([2:0]), mask_t ([14:0]), scroll_state_t enum {IDLE, SCROLL}.
- One combinational sub-module, platform_mask_shaper, holds the mask rules. The scroll counter and issuer stay in the top.

Test Plan:
- Reset, then landing with doodle_y = 200, then 20 frame_ticks -> exactly 16 scroll_en pulses; height_score = 192; busy = 0 after the 16th.
- Landing with doodle_y = 450 -> no scroll_en and state stays IDLE.
- A second landing after the 5th step -> 21 pulses in total; height_score = 252.
- group_top_y[2] = 486 and [4] = 500 at frame_tick, ready held 0 for 3 cycles:
  - Response: group 2 is issued first, and group and mask stay stable until ready.
  - Then group 4 is issued; pending = 0 afterwards.
- rand_bits = 15'b000_000_111_000_000 -> recycle_mask = 15'b010_010_111_010_010. With MIN_ONE_PER_ROW = 0 and rand_bits = 0 -> mask = 15'h4000.
- Handshake on group 1 in the same cycle as a frame_tick while group_top_y[1] = 482 -> group 1 is not re-issued. Also assert rst with recycle_valid high -> valid = 0 next cycle and no further requests.
